// File: rtl/axil_master.sv
// rtl/axil_master.sv - AXI-Lite initiator for the FIR register port, one command in flight
module axil_master #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = 255
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [pADDR_WIDTH-1:0] cmd_addr,
  input  logic [pDATA_WIDTH-1:0] cmd_wdata,
  output logic                   rsp_valid,
  output logic [pDATA_WIDTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata
);

  localparam int CW = $clog2(pTIMEOUT + 1);
  // Abort fires on the edge closing the pTIMEOUT-th waiting cycle of a phase.
  localparam logic [CW-1:0] T_LAST = CW'(pTIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_DATA, RESP} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   aw_done, aw_done_n;
  logic                   w_done, w_done_n;
  logic                   cmd_ready_n, busy_n, rsp_valid_n, rsp_err_n;
  logic [pDATA_WIDTH-1:0] rsp_rdata_n, wdata_n;
  logic                   awvalid_n, wvalid_n, arvalid_n, rready_n;
  logic [pADDR_WIDTH-1:0] awaddr_n, araddr_n;
  logic                   aw_fin, w_fin;

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    aw_done_n   = aw_done;
    w_done_n    = w_done;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    awvalid_n   = awvalid;
    awaddr_n    = awaddr;
    wvalid_n    = wvalid;
    wdata_n     = wdata;
    arvalid_n   = arvalid;
    araddr_n    = araddr;
    rready_n    = rready;
    aw_fin      = aw_done | (awvalid & awready);
    w_fin       = w_done | (wvalid & wready);

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cnt_n = '0;
          if (cmd_write) begin
            awaddr_n  = cmd_addr;
            wdata_n   = cmd_wdata;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            state_n   = WRITE;
          end else begin
            araddr_n  = cmd_addr;
            arvalid_n = 1'b1;
            state_n   = RD_ADDR;
          end
        end
      end

      WRITE: begin
        // Address and data handshakes are tracked independently; no B channel.
        cnt_n     = cnt + CW'(1);
        awvalid_n = awvalid & ~awready;
        wvalid_n  = wvalid & ~wready;
        aw_done_n = aw_fin;
        w_done_n  = w_fin;
        if (aw_fin && w_fin) begin
          rsp_err_n   = 1'b0;
          rsp_rdata_n = '0;
          state_n     = RESP;
        end else if (cnt == T_LAST) begin
          awvalid_n   = 1'b0;
          wvalid_n    = 1'b0;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = '0;
          state_n     = RESP;
        end
      end

      RD_ADDR: begin
        cnt_n = cnt + CW'(1);
        if (arvalid && arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          cnt_n     = '0;
          state_n   = RD_DATA;
        end else if (cnt == T_LAST) begin
          arvalid_n   = 1'b0;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = '0;
          state_n     = RESP;
        end
      end

      RD_DATA: begin
        cnt_n = cnt + CW'(1);
        if (rvalid && rready) begin
          rsp_rdata_n = rdata;
          rsp_err_n   = 1'b0;
          rready_n    = 1'b0;
          state_n     = RESP;
        end else if (cnt == T_LAST) begin
          rready_n    = 1'b0;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = '0;
          state_n     = RESP;
        end
      end

      RESP: state_n = IDLE;

      default: state_n = IDLE;
    endcase

    rsp_valid_n = (state_n == RESP);
    cmd_ready_n = (state_n == IDLE);
    busy_n      = (state_n != IDLE);
  end

  // State, counter and registered outputs; reset aborts any transaction at once.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      wvalid    <= 1'b0;
      wdata     <= '0;
      arvalid   <= 1'b0;
      araddr    <= '0;
      rready    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
      cmd_ready <= cmd_ready_n;
      busy      <= busy_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
      awvalid   <= awvalid_n;
      awaddr    <= awaddr_n;
      wvalid    <= wvalid_n;
      wdata     <= wdata_n;
      arvalid   <= arvalid_n;
      araddr    <= araddr_n;
      rready    <= rready_n;
    end
  end

endmodule
